// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, next-PC select encodings and field helpers.
package mips_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port, r0 hard-wired to zero, synchronous clear on reset.
module reg_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0]     wd_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra2_i,
  output logic [DATA_WIDTH-1:0]     rd1_o,
  output logic [DATA_WIDTH-1:0]     rd2_o
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  assign wr_en = we_i && (wa_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          regs_q[gi] <= '0;
        end else if (wr_en && (wa_i == gi[REG_ADDR_WIDTH-1:0])) begin
          regs_q[gi] <= wd_i;
        end
      end
    end
  endgenerate

  // A write landing this cycle is visible to the reader immediately.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (ra1_i == '0)                      rd1_o = '0;
    else if (wr_en && (wa_i == ra1_i))    rd1_o = wd_i;
    if (ra2_i == '0)                      rd2_o = '0;
    else if (wr_en && (wa_i == ra2_i))    rd2_o = wd_i;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, register file, branch compare and next-PC select.
// Define DECODE_BNE_EN to resolve BNE in decode; otherwise BNE is treated as non-branch.
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     InstrF,
  input  logic [DATA_WIDTH-1:0]     PCPlus4F,
  input  logic                      StallD,
  input  logic                      FlushD,
  input  logic                      ForwardAD,
  input  logic                      ForwardBD,
  input  logic [DATA_WIDTH-1:0]     ALUOutM,
  input  logic                      RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     InstrD,
  output logic [DATA_WIDTH-1:0]     PCPlus4D,
  output logic [DATA_WIDTH-1:0]     RD1D,
  output logic [DATA_WIDTH-1:0]     RD2D,
  output logic [DATA_WIDTH-1:0]     SignImmD,
  output logic [REG_ADDR_WIDTH-1:0] RsD,
  output logic [REG_ADDR_WIDTH-1:0] RtD,
  output logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic [DATA_WIDTH-1:0]     PCBranchD,
  output logic [DATA_WIDTH-1:0]     PCJump,
  output logic [1:0]                PCSrcD
);

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
  logic [DATA_WIDTH-1:0] cmp_a, cmp_b;
  logic [5:0]            opcode;
  pcsrc_e                pcsrc;

  // Stall outranks flush so a held instruction is not lost.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    if (!StallD) begin
      if (FlushD) begin
        instr_d   = '0;
        pcplus4_d = '0;
      end else begin
        instr_d   = InstrF;
        pcplus4_d = PCPlus4F;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCPlus4D = pcplus4_q;
  assign RsD      = instr_q[25:21];
  assign RtD      = instr_q[20:16];
  assign RdD      = instr_q[15:11];
  assign opcode   = instr_q[31:26];
  assign SignImmD = sign_ext16(instr_q[15:0]);

  reg_file #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_reg_file (
    .clk_i (CLK),
    .rst_i (RST),
    .we_i  (RegWriteW),
    .wa_i  (WriteRegW),
    .wd_i  (ResultW),
    .ra1_i (instr_q[25:21]),
    .ra2_i (instr_q[20:16]),
    .rd1_o (RD1D),
    .rd2_o (RD2D)
  );

  assign cmp_a     = ForwardAD ? ALUOutM : RD1D;
  assign cmp_b     = ForwardBD ? ALUOutM : RD2D;
  assign PCBranchD = {SignImmD[DATA_WIDTH-3:0], 2'b00} + pcplus4_q;
  assign PCJump    = {pcplus4_q[DATA_WIDTH-1 -: 4], instr_q[25:0], 2'b00};

  // A stalled decode must not redirect fetch with a stale target.
  always_comb begin
    pcsrc = PCSRC_PLUS4;
    if (!StallD) begin
      case (opcode)
        OP_BEQ:  if (cmp_a == cmp_b) pcsrc = PCSRC_BRANCH;
`ifdef DECODE_BNE_EN
        OP_BNE:  if (cmp_a != cmp_b) pcsrc = PCSRC_BRANCH;
`endif
        OP_J:    pcsrc = PCSRC_JUMP;
        default: pcsrc = PCSRC_PLUS4;
      endcase
    end
  end

  assign PCSrcD = pcsrc;

endmodule
